sync_fifo_pro: RTL

Parametrised synchronous FIFO; next generation of the team's single-clock FIFO. Adds non-power-of-two depth, parameterised almost-full/almost-empty thresholds, a level output, and simultaneous read/write when full. Also adds sticky error flags and an optional first-word-fall-through (FWFT) read mode. It sits between a producer and consumer in one clock domain, with the same flag semantics as the existing FIFO so benches and scoreboards carry over.

---
 rtl/sync_fifo_pro.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sync_fifo_pro.sv
// sync_fifo_pro: parametrised single-clock FIFO with any integer depth,
// almost-full/almost-empty thresholds, a level output, sticky error flags
// and simultaneous read/write when full.
//
// Optional feature macro: SYNC_FIFO_PRO_FWFT_EN
//   undefined : standard mode, data_out registered and loaded on an accepted read
//   defined   : first-word-fall-through, data_out shows the head word while !empty
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en, data_in      write request and data
//   rd_en               read request (FWFT: pop of the head word)
//   err_clr             synchronous clear of ovf_sticky/udf_sticky
//   data_out, data_valid read data and its qualifier
//   wr_ack              previous-cycle write accepted (pulse)
//   overflow, underflow previous-cycle write/read rejected (pulse)
//   ovf_sticky, udf_sticky  error flags held until err_clr
//   full, empty, almostfull, almostempty  combinational from level
//   level               number of stored words
module sync_fifo_pro #(
    parameter int unsigned FIFO_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 1,
    parameter int unsigned AEMPTY_THRESH = 1,
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH),
    localparam int unsigned LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic                  err_clr,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ovf_sticky,
    output logic                  udf_sticky,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [LVL_W-1:0]      level
);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [FIFO_WIDTH-1:0] dout_q;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  wr_rej;
    logic                  rd_rej;

    // A write into a full FIFO is allowed when a read frees the head slot
    // on the same edge.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);
    assign wr_rej = wr_en && !wr_acc;
    assign rd_rej = rd_en && !rd_acc;

    // Status flags derived from the stored-word count
    assign full        = (level == LVL_W'(FIFO_DEPTH));
    assign empty       = (level == '0);
    assign almostfull  = (32'(level) >= AFULL_THRESH);
    assign almostempty = (level != '0) && (32'(level) <= AEMPTY_THRESH);

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers and level; explicit wrap so non-power-of-two depths work
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Handshake pulses and sticky errors; a new event wins over err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack     <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else begin
            wr_ack     <= wr_acc;
            overflow   <= wr_rej;
            underflow  <= rd_rej;
            ovf_sticky <= wr_rej || (ovf_sticky && !err_clr);
            udf_sticky <= rd_rej || (udf_sticky && !err_clr);
        end
    end

    // Last word popped; also the hold value of data_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem[rd_ptr];
        end
    end

`ifdef SYNC_FIFO_PRO_FWFT_EN
    // Head word falls through whenever something is stored
    assign data_out   = empty ? dout_q : mem[rd_ptr];
    assign data_valid = !empty;
`else
    logic valid_q;

    // Valid for exactly the cycle after an accepted read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_acc;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
`endif

endmodule
